// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// ready/request memory handshake. Strobes are decoded from state plus op/funct.
module mc_ctrl #(
    parameter int ALUOP_W = 4,
    parameter bit JR_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_rdy,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         npc_op,
    output logic               reg_write,
    output logic [1:0]         gpr_sel,
    output logic [1:0]         wd_sel,
    output logic               ext_op,
    output logic               alu_srcb,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state,
    output logic               illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        K_ILL  = 4'd0, K_R  = 4'd1, K_IALU = 4'd2, K_LW = 4'd3, K_SW   = 4'd4,
        K_BR   = 4'd5, K_J  = 4'd6, K_JAL  = 4'd7, K_JR = 4'd8, K_JALR = 4'd9
    } kind_t;

    state_t     state_r;
    kind_t      kind_s;
    logic [3:0] alu_s;
    logic       srcb_s;
    logic       ext_s;
    logic       bne_s;

    // Instruction classification and ALU control from op/funct
    always_comb begin
        kind_s = K_ILL;
        alu_s  = 4'd0;
        srcb_s = 1'b0;
        ext_s  = 1'b0;
        bne_s  = 1'b0;
        case (op)
            6'h00: begin
                kind_s = K_R;
                case (funct)
                    6'h20, 6'h21: alu_s = 4'd1;
                    6'h22, 6'h23: alu_s = 4'd2;
                    6'h24:        alu_s = 4'd3;
                    6'h25:        alu_s = 4'd4;
                    6'h2A:        alu_s = 4'd5;
                    6'h2B:        alu_s = 4'd6;
                    6'h27:        alu_s = 4'd7;
                    6'h00:        alu_s = 4'd8;
                    6'h02:        alu_s = 4'd9;
                    6'h08:        kind_s = JR_EN ? K_JR : K_ILL;
                    6'h09:        kind_s = JR_EN ? K_JALR : K_ILL;
                    default:      kind_s = K_ILL;
                endcase
            end
            6'h08:   begin kind_s = K_IALU; alu_s = 4'd1;  srcb_s = 1'b1; ext_s = 1'b1; end
            6'h0A:   begin kind_s = K_IALU; alu_s = 4'd5;  srcb_s = 1'b1; ext_s = 1'b1; end
            6'h0C:   begin kind_s = K_IALU; alu_s = 4'd3;  srcb_s = 1'b1; end
            6'h0D:   begin kind_s = K_IALU; alu_s = 4'd4;  srcb_s = 1'b1; end
            6'h0F:   begin kind_s = K_IALU; alu_s = 4'd10; srcb_s = 1'b1; end
            6'h23:   begin kind_s = K_LW;   alu_s = 4'd1;  srcb_s = 1'b1; ext_s = 1'b1; end
            6'h2B:   begin kind_s = K_SW;   alu_s = 4'd1;  srcb_s = 1'b1; ext_s = 1'b1; end
            6'h04:   begin kind_s = K_BR;   alu_s = 4'd2;  ext_s = 1'b1; end
            6'h05:   begin kind_s = K_BR;   alu_s = 4'd2;  ext_s = 1'b1; bne_s = 1'b1; end
            6'h02:   kind_s = K_J;
            6'h03:   kind_s = K_JAL;
            default: kind_s = K_ILL;
        endcase
    end

    // State sequencing; unused encodings recover to FETCH
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:  state_r <= mem_rdy ? S_DECODE : S_FETCH;
                S_DECODE: state_r <= (kind_s inside {K_ILL, K_J, K_JAL, K_JR, K_JALR})
                                     ? S_FETCH : S_EXEC;
                S_EXEC: begin
                    case (kind_s)
                        K_LW, K_SW: state_r <= S_MEM;
                        K_BR:       state_r <= S_FETCH;
                        default:    state_r <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (!mem_rdy)          state_r <= S_MEM;
                    else if (kind_s == K_SW) state_r <= S_FETCH;
                    else                   state_r <= S_WB;
                end
                S_WB:    state_r <= S_FETCH;
                default: state_r <= S_FETCH;
            endcase
        end
    end

    // Per-state strobes; everything is forced low while reset is held
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        npc_op    = 2'b00;
        reg_write = 1'b0;
        gpr_sel   = 2'b00;
        wd_sel    = 2'b00;
        ext_op    = 1'b0;
        alu_srcb  = 1'b0;
        alu_op    = {ALUOP_W{1'b0}};
        illegal   = 1'b0;
        state     = 3'd0;
        if (!rstn) begin
            mem_req = 1'b0;
        end else begin
            state = state_r;
            case (state_r)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_rdy;
                    pc_write = mem_rdy;
                end
                S_DECODE: begin
                    case (kind_s)
                        K_J:    begin pc_write = 1'b1; npc_op = 2'b10; end
                        K_JAL:  begin
                            pc_write = 1'b1; npc_op = 2'b10;
                            reg_write = 1'b1; gpr_sel = 2'b10; wd_sel = 2'b10;
                        end
                        K_JR:   begin pc_write = 1'b1; npc_op = 2'b11; end
                        K_JALR: begin
                            pc_write = 1'b1; npc_op = 2'b11;
                            reg_write = 1'b1; wd_sel = 2'b10;
                        end
                        K_ILL:   illegal = 1'b1;
                        default: illegal = 1'b0;
                    endcase
                end
                S_EXEC: begin
                    alu_op   = ALUOP_W'(alu_s);
                    alu_srcb = srcb_s;
                    ext_op   = ext_s;
                    if (kind_s == K_BR) begin
                        pc_write = zero ^ bne_s;
                        npc_op   = 2'b01;
                    end else begin
                        pc_write = 1'b0;
                    end
                end
                S_MEM: begin
                    alu_op   = ALUOP_W'(alu_s);
                    alu_srcb = srcb_s;
                    ext_op   = ext_s;
                    mem_req  = 1'b1;
                    mem_we   = (kind_s == K_SW);
                end
                S_WB: begin
                    alu_op    = ALUOP_W'(alu_s);
                    alu_srcb  = srcb_s;
                    ext_op    = ext_s;
                    reg_write = 1'b1;
                    gpr_sel   = (kind_s == K_R) ? 2'b00 : 2'b01;
                    wd_sel    = (kind_s == K_LW) ? 2'b01 : 2'b00;
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

endmodule
